if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Fetch-to-decode pipeline stage.
- Sits between the fetch unit (PC + instruction memory) and the decode stage's 32-bit pipeline registers.
- Carries {pc, instr} across a valid/ready handshake using a 2-entry skid buffer, so decode back-pressure never drops a fetched instruction.
- Supports a branch/jump flush and keeps a saturating decode-stall counter for simulation statistics.

Parameters:
- PC_WIDTH, 32, width of program counter field.
- INSTR_WIDTH, 32, width of instruction word.
- CNT_WIDTH, 16, width of stall counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- flush  input  1  discard all buffered entries (branch/jump taken).
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  stage can accept an entry this cycle.
- in_pc  input  PC_WIDTH  PC of fetched instruction.
- in_instr  input  INSTR_WIDTH  fetched instruction word.
- out_valid  output  1  {out_pc, out_instr} valid to decode.
- out_ready  input  1  decode consumes entry this cycle.
- out_pc  output  PC_WIDTH  PC of head entry.
- out_instr  output  INSTR_WIDTH  instruction of head entry.
- stall_cnt  output  CNT_WIDTH  cycles decode stalled on a valid entry.

Behaviour:
- Storage: main register (head, drives outputs) and skid register.
- State machine: EMPTY (none valid), ONE (main valid), FULL (main + skid valid).
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Neither is evaluated in reset or flush cycles.
- Derived outputs:
  - in_ready = reset & (state != FULL). It is 0 while reset is low and decoded from registered state only.
  - out_valid = (state != EMPTY).
- Transitions with reset high and flush low:
  - EMPTY: in_fire -> ONE, main <= in. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> FULL, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY. Main holds its old value.
  - ONE, neither -> stay.
  - FULL: out_fire -> ONE, main <= skid. in_fire is impossible in FULL.
- Latency: an entry accepted at edge N is on out_* after edge N. Throughput is 1 entry/cycle while out_ready stays high.
- Ordering: strict FIFO. Skid contents always leave after main contents.
- Stability: while out_valid=1 and out_ready=0, out_pc and out_instr must not change.
- Flush:
  - Any state -> EMPTY at next edge.
  - main and skid are cleared to 0.
  - An in_valid or out_ready asserted in the flush cycle is ignored: the entry is not accepted and the head is not counted as consumed.
  - in_ready is 1 in the cycle after a flush.
- Reset (reset=0 at an edge): overrides flush and all handshakes.
  - state=EMPTY, out_pc=0, out_instr=0, skid=0, stall_cnt=0.
  - out_valid=0 and in_ready=0 during reset cycles.
  - A reset arriving mid-transfer drops all entries.
- stall_cnt:
  - Increments by 1 at each edge where out_valid & !out_ready & !flush & reset.
  - Saturates at all-ones (0xFFFF) and does not wrap.
  - Cleared only by reset, not by flush.
- When EMPTY, out_pc and out_instr hold their last value, or 0 after reset/flush.

Test Plan:
- Reset: reset=0 for 2 cycles with in_valid=1 and flush=1.
  - Required: out_valid=0, in_ready=0, out_pc=0, out_instr=0, stall_cnt=0.
  - After reset=1: in_ready=1 and out_valid=0.
- Streaming: out_ready=1; push pc=0x00,0x04,0x08 with instr 0x20080005,0x20090002,0x01095020 on consecutive cycles.
  - Required: each entry appears on out_* one cycle later, in order.
  - in_ready stays 1; stall_cnt stays 0.
- Back-pressure: push pc=0x10 and 0x14 with out_ready=0.
  - Required: state FULL, in_ready=0, out_pc=0x10 held, stall_cnt increments once per cycle.
  - Then raise out_ready: 0x10 then 0x14 are delivered and in_ready returns to 1.
- Flush: FULL state holding 0x10 and 0x14; assert flush with in_valid=1 pc=0x40.
  - Required next cycle: out_valid=0, out_pc=0, in_ready=1, 0x40 not delivered, stall_cnt unchanged.
- Simultaneous push and pop in ONE: main=0x20, push 0x24 with out_ready=1.
  - Required: out_pc=0x24 next cycle and the state stays ONE.
- Saturation: hold out_valid=1, out_ready=0 for 65540 cycles.
  - Required: stall_cnt=0xFFFF and holds; after reset, stall_cnt=0.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline stage: {pc, instr} passes through a 2-entry skid
// buffer so decode back-pressure never drops a fetched instruction.
module if_id_skid_stage #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [CNT_WIDTH-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [PC_WIDTH-1:0]    main_pc_reg, main_pc_next;
  logic [INSTR_WIDTH-1:0] main_instr_reg, main_instr_next;
  logic [PC_WIDTH-1:0]    skid_pc_reg, skid_pc_next;
  logic [INSTR_WIDTH-1:0] skid_instr_reg, skid_instr_next;
  logic [CNT_WIDTH-1:0]   stall_cnt_reg, stall_cnt_next;
  logic                   in_fire, out_fire;

  // Handshakes are masked in flush cycles; in_ready already carries reset.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready & ~flush & reset;

  // State register and storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= EMPTY;
      main_pc_reg    <= '0;
      main_instr_reg <= '0;
      skid_pc_reg    <= '0;
      skid_instr_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      main_pc_reg    <= main_pc_next;
      main_instr_reg <= main_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY:   if (in_fire) state_next = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_next = FULL;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        FULL:    if (out_fire) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Datapath next values; main is the head and always leaves first.
  always_comb begin
    main_pc_next    = main_pc_reg;
    main_instr_next = main_instr_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;
    if (flush) begin
      main_pc_next    = '0;
      main_instr_next = '0;
      skid_pc_next    = '0;
      skid_instr_next = '0;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_pc_next    = in_pc;
            main_instr_next = in_instr;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc_next    = in_pc;
            main_instr_next = in_instr;
          end else if (in_fire) begin
            skid_pc_next    = in_pc;
            skid_instr_next = in_instr;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_pc_next    = skid_pc_reg;
            main_instr_next = skid_instr_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating stall counter; flush does not clear it.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (out_valid && !out_ready && !flush && (stall_cnt_reg != {CNT_WIDTH{1'b1}}))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  // Output decode from registered state
  always_comb begin
    in_ready  = reset & (state_reg != FULL);
    out_valid = (state_reg != EMPTY);
  end

  assign out_pc    = main_pc_reg;
  assign out_instr = main_instr_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a queue model of the stage
// predicts every output each cycle and scores entries as decode pops them.
module tb_if_id_skid_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  entry_t      hold;
  logic [15:0] exp_stall;
  bit          model_valid;
  int          vectors;
  int          miscompares;

  if_id_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: compare DUT against the model just before the rising edge,
  // advance the model by the handshakes of this cycle, return at negedge.
  task automatic step();
    entry_t     e;
    entry_t     exp_head;
    logic       exp_ov, exp_ir, ei, eo;
    #2;
    exp_ov   = (q.size() > 0);
    exp_ir   = reset && (q.size() < 2);
    exp_head = (q.size() > 0) ? q[0] : hold;
    if (model_valid) begin
      vectors++;
      if (out_valid !== exp_ov) begin
        miscompares++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_ov, $time);
      end
      vectors++;
      if (in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ir, $time);
      end
      vectors++;
      if (out_pc !== exp_head.pc || out_instr !== exp_head.instr) begin
        miscompares++;
        $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h at %0t",
                 out_pc, out_instr, exp_head.pc, exp_head.instr, $time);
      end
      vectors++;
      if (stall_cnt !== exp_stall) begin
        miscompares++;
        $display("FAIL stall_cnt: got %h expected %h at %0t", stall_cnt, exp_stall, $time);
      end
    end
    ei = exp_ir && in_valid && !flush;
    eo = exp_ov && out_ready && !flush && reset;
    if (!reset) begin
      q.delete();
      hold        = '0;
      exp_stall   = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (exp_ov && !out_ready && !flush && exp_stall != 16'hFFFF)
        exp_stall = exp_stall + 16'd1;
      if (flush) begin
        q.delete();
        hold = '0;
      end else begin
        if (eo) begin
          e    = q.pop_front();
          hold = e;
          $display("deliver pc=%h instr=%h", e.pc, e.instr);
        end
        if (ei) begin
          e.pc    = in_pc;
          e.instr = in_instr;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'hDEAD_0000;
    in_instr = 32'hBEEF_0000;
    out_ready = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b expected 0/0", out_valid, in_ready);
    end
    vectors++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0 || stall_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got pc=%h instr=%h stall=%h expected zeros", out_pc, out_instr, stall_cnt);
    end
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'h00, 32'h04, 32'h08};
    ins = '{32'h20080005, 32'h20090002, 32'h01095020};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = pcs[i];
      in_instr = ins[i];
      step();
      vectors++;
      if (out_pc !== pcs[i] || out_instr !== ins[i] || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
        miscompares++;
        $display("FAIL stream%0d: got pc=%h instr=%h rdy=%b stall=%h expected pc=%h instr=%h rdy=1 stall=0",
                 i, out_pc, out_instr, in_ready, stall_cnt, pcs[i], ins[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_pressure();
    logic [15:0] s0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h10;
    in_instr  = 32'hA000_0010;
    step();
    in_pc    = 32'h14;
    in_instr = 32'hA000_0014;
    step();
    s0       = stall_cnt;
    in_pc    = 32'h18;
    in_instr = 32'hA000_0018;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (in_ready !== 1'b0 || out_pc !== 32'h10 || stall_cnt !== s0 + 16'(i + 1)) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got rdy=%b pc=%h stall=%h expected rdy=0 pc=10 stall=%h",
                 i, in_ready, out_pc, stall_cnt, s0 + 16'(i + 1));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_pc !== 32'h14 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_skid: got pc=%h valid=%b rdy=%b expected pc=14 valid=1 rdy=1", out_pc, out_valid, in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 32'h14) begin
      miscompares++;
      $display("FAIL bp_drain: got valid=%b pc=%h expected valid=0 pc=14 held", out_valid, out_pc);
    end
  endtask

  task automatic test_flush();
    logic [15:0] s0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h10;
    in_instr  = 32'hB000_0010;
    step();
    in_pc    = 32'h14;
    in_instr = 32'hB000_0014;
    step();
    s0        = stall_cnt;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h40;
    in_instr  = 32'hB000_0040;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || in_ready !== 1'b1 || stall_cnt !== s0) begin
      miscompares++;
      $display("FAIL flush: got valid=%b pc=%h instr=%h rdy=%b stall=%h expected 0/0/0/1/%h",
               out_valid, out_pc, out_instr, in_ready, stall_cnt, s0);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop: got out_valid=%b expected 0 (pc 0x40 must not arrive)", out_valid);
    end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h20;
    in_instr  = 32'hC000_0020;
    step();
    out_ready = 1'b1;
    in_pc     = 32'h24;
    in_instr  = 32'hC000_0024;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_pc !== 32'h24 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_pop: got pc=%h valid=%b rdy=%b expected pc=24 valid=1 rdy=1", out_pc, out_valid, in_ready);
    end
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h30;
    in_instr  = 32'hD000_0030;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 65540; i++) step();
    vectors++;
    if (stall_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL saturate: got %h expected ffff", stall_cnt);
    end
    step();
    step();
    vectors++;
    if (stall_cnt !== 16'hFFFF || out_pc !== 32'h30) begin
      miscompares++;
      $display("FAIL sat_hold: got stall=%h pc=%h expected ffff/30", stall_cnt, out_pc);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++;
    if (stall_cnt !== 16'h0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL sat_reset: got stall=%h valid=%b pc=%h expected 0/0/0", stall_cnt, out_valid, out_pc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      in_pc     = 32'h1000 + 32'(i * 4);
      in_instr  = $urandom;
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_valid = 1'b0;
    exp_stall   = '0;
    hold        = '0;
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_instr    = '0;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_push_pop();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
